// File: rtl/dm_mmio_responder_if.sv
// Core data-port bus between the single-cycle core and its memory-side responder.
// Reads are combinational from addr; writes commit on the next rising clock edge.
interface dm_mmio_responder_if;
  logic [31:0] addr;
  logic [3:0]  wea;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output wea, output din, input dout);
  modport slave  (input addr, input wea, input din, output dout);
endinterface

// File: rtl/dm_mmio_responder.sv
// Data-port responder: word RAM with byte strobes plus an MMIO window holding the LEDs,
// the synchronised switches, a free-running cycle counter and a compare timer with an IRQ.
module dm_mmio_responder #(
  parameter int unsigned RAM_AW   = 10,
  parameter logic [15:0] MMIO_TAG = 16'hFFFF,
  parameter int unsigned SW_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  dm_mmio_responder_if.slave  bus,
  input  logic [SW_W-1:0]     sw,
  output logic [SW_W-1:0]     led,
  output logic                irq
);

  localparam logic [7:0] OffLed   = 8'h00;
  localparam logic [7:0] OffSw    = 8'h04;
  localparam logic [7:0] OffCycle = 8'h08;
  localparam logic [7:0] OffTcmp  = 8'h0C;
  localparam logic [7:0] OffTctrl = 8'h10;
  localparam logic [7:0] OffTcnt  = 8'h14;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  logic [31:0] mem [2**RAM_AW];

  logic              mmio;
  logic [7:0]        off;
  logic [RAM_AW-1:0] idx;
  logic [31:0]       wmask;
  logic              mmio_wr;

  logic [SW_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic [31:0]     cycle_q;
  logic [31:0]     tcmp_q, tcmp_d;
  logic [31:0]     tcnt_q, tcnt_d;
  logic            en_q, en_d;
  logic            pend_q, pend_d;
  logic [31:0]     led_merged;
  logic            hit;

  assign mmio    = (bus.addr[31:16] == MMIO_TAG);
  assign off     = bus.addr[7:0];
  assign idx     = bus.addr[RAM_AW+1:2];
  assign mmio_wr = mmio && (bus.wea != 4'b0000);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{bus.wea[i]}};
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wea[i]) mem[idx][8*i +: 8] <= bus.din[8*i +: 8];
      end
    end
  end

  assign hit        = en_q && (tcnt_q == tcmp_q);
  assign led_merged = merge(32'(led_q), bus.din, wmask);

  always_comb begin
    led_d  = led_q;
    tcmp_d = tcmp_q;
    tcnt_d = tcnt_q;
    en_d   = en_q;
    pend_d = pend_q;

    if (mmio_wr && off == OffLed)  led_d  = led_merged[SW_W-1:0];
    if (mmio_wr && off == OffTcmp) tcmp_d = merge(tcmp_q, bus.din, wmask);
    if (mmio_wr && off == OffTctrl && bus.wea[0]) begin
      en_d = bus.din[0];
      if (bus.din[1]) pend_d = 1'b0;
    end

    if (en_q) tcnt_d = hit ? 32'd0 : tcnt_q + 32'd1;
    // Hardware set of pend outranks a coincident W1C; a CPU write to TCNT outranks hardware.
    if (hit) pend_d = 1'b1;
    if (mmio_wr && off == OffTcnt) tcnt_d = merge(tcnt_q, bus.din, wmask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cycle_q <= '0;
      tcmp_q  <= 32'hFFFF_FFFF;
      tcnt_q  <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      cycle_q <= cycle_q + 32'd1;
      tcmp_q  <= tcmp_d;
      tcnt_q  <= tcnt_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bus.dout = '0;
    if (mmio) begin
      case (off)
        OffLed:   bus.dout = 32'(led_q);
        OffSw:    bus.dout = 32'(sw_s2_q);
        OffCycle: bus.dout = cycle_q;
        OffTcmp:  bus.dout = tcmp_q;
        OffTctrl: bus.dout = {30'd0, pend_q, en_q};
        OffTcnt:  bus.dout = tcnt_q;
        default:  bus.dout = '0;
      endcase
    end else begin
      bus.dout = mem[idx];
    end
  end

  assign led = led_q;
  assign irq = pend_q & en_q;

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Directed bench for dm_mmio_responder: RAM strobes, LED, switch sync, cycle counter,
// compare timer with W1C/priority cases, and asynchronous reset in mid-operation.
module tb_dm_mmio_responder;

  localparam logic [31:0] ALed   = 32'hFFFF_0000;
  localparam logic [31:0] ASw    = 32'hFFFF_0004;
  localparam logic [31:0] ACycle = 32'hFFFF_0008;
  localparam logic [31:0] ATcmp  = 32'hFFFF_000C;
  localparam logic [31:0] ATctrl = 32'hFFFF_0010;
  localparam logic [31:0] ATcnt  = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;
  int          vectors = 0;
  int          miscompares = 0;

  dm_mmio_responder_if bus ();

  dm_mmio_responder #(
    .RAM_AW  (10),
    .MMIO_TAG(16'hFFFF),
    .SW_W    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .sw   (sw),
    .led  (led),
    .irq  (irq)
  );

  always #10 clk = ~clk;

  // One rising edge; returns just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.addr = a;
    bus.din  = d;
    bus.wea  = s;
    step();
    bus.wea  = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.wea  = 4'b0000;
    #1;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    reset = 1'b1;
    #25;
    vectors++;
    if (led !== 16'h0000) begin
      miscompares++; $display("FAIL reset_led: got %h expected %h", led, 16'h0000);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL reset_irq: got %b expected %b", irq, 1'b0);
    end
    rd(ATcmp, got);
    vectors++;
    if (got !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL reset_tcmp: got %h expected %h", got, 32'hFFFF_FFFF);
    end
    rd(ACycle, got);
    vectors++;
    if (got !== 32'h0) begin
      miscompares++; $display("FAIL reset_cycle: got %h expected %h", got, 32'h0);
    end
    rd(ATctrl, got);
    vectors++;
    if (got !== 32'h0) begin
      miscompares++; $display("FAIL reset_tctrl: got %h expected %h", got, 32'h0);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_ram_strobe();
    logic [31:0] got;
    wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h40, 32'h0000_55AA, 4'b0010);
    rd(32'h40, got);
    vectors++;
    if (got !== 32'hDEAD_55EF) begin
      miscompares++; $display("FAIL ram_strobe: got %h expected %h", got, 32'hDEAD_55EF);
    end
    // 2**10 words: byte address 0x1040 aliases onto 0x40.
    rd(32'h1040, got);
    vectors++;
    if (got !== 32'hDEAD_55EF) begin
      miscompares++; $display("FAIL ram_alias: got %h expected %h", got, 32'hDEAD_55EF);
    end
    wr(32'h44, 32'h1111_1111, 4'b1111);
    bus.addr = 32'h44;
    bus.din  = 32'h2222_2222;
    bus.wea  = 4'b1111;
    #1;
    got = bus.dout;
    vectors++;
    if (got !== 32'h1111_1111) begin
      miscompares++; $display("FAIL ram_no_bypass: got %h expected %h", got, 32'h1111_1111);
    end
    step();
    rd(32'h44, got);
    vectors++;
    if (got !== 32'h2222_2222) begin
      miscompares++; $display("FAIL ram_after_write: got %h expected %h", got, 32'h2222_2222);
    end
  endtask

  task automatic test_led();
    logic [31:0] got;
    wr(ALed, 32'h0001_A5A5, 4'b1111);
    vectors++;
    if (led !== 16'hA5A5) begin
      miscompares++; $display("FAIL led_pin: got %h expected %h", led, 16'hA5A5);
    end
    rd(ALed, got);
    vectors++;
    if (got !== 32'h0000_A5A5) begin
      miscompares++; $display("FAIL led_readback: got %h expected %h", got, 32'h0000_A5A5);
    end
    wr(ALed, 32'h0000_0077, 4'b0001);
    vectors++;
    if (led !== 16'hA577) begin
      miscompares++; $display("FAIL led_strobe: got %h expected %h", led, 16'hA577);
    end
    wr(32'hFFFF_0020, 32'h1234_5678, 4'b1111);
    rd(32'hFFFF_0020, got);
    vectors++;
    if (got !== 32'h0) begin
      miscompares++; $display("FAIL unmapped_read: got %h expected %h", got, 32'h0);
    end
    vectors++;
    if (led !== 16'hA577) begin
      miscompares++; $display("FAIL unmapped_side_effect: got %h expected %h", led, 16'hA577);
    end
  endtask

  task automatic test_sw_sync();
    logic [31:0] got;
    sw = 16'h1234;
    rd(ASw, got);
    vectors++;
    if (got !== 32'h0) begin
      miscompares++; $display("FAIL sw_lag0: got %h expected %h", got, 32'h0);
    end
    step();
    rd(ASw, got);
    vectors++;
    if (got !== 32'h0) begin
      miscompares++; $display("FAIL sw_lag1: got %h expected %h", got, 32'h0);
    end
    step();
    rd(ASw, got);
    vectors++;
    if (got !== 32'h0000_1234) begin
      miscompares++; $display("FAIL sw_lag2: got %h expected %h", got, 32'h0000_1234);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] c1, c2;
    rd(ACycle, c1);
    repeat (5) step();
    rd(ACycle, c2);
    vectors++;
    if (c2 - c1 !== 32'd5) begin
      miscompares++; $display("FAIL cycle_delta: got %0d expected %0d", c2 - c1, 5);
    end
    rd(ACycle, c1);
    wr(ACycle, 32'h0, 4'b1111);
    rd(ACycle, c2);
    vectors++;
    if (c2 !== c1 + 32'd1) begin
      miscompares++; $display("FAIL cycle_write_ignored: got %h expected %h", c2, c1 + 32'd1);
    end
  endtask

  task automatic test_timer();
    logic [31:0] got;
    logic [31:0] exp_cnt [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    wr(ATcmp, 32'd3, 4'b1111);
    wr(ATctrl, 32'd1, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      rd(ATcnt, got);
      vectors++;
      if (got !== exp_cnt[i]) begin
        miscompares++; $display("FAIL timer_count[%0d]: got %0d expected %0d", i, got, exp_cnt[i]);
      end
      vectors++;
      if (irq !== (i == 4)) begin
        miscompares++; $display("FAIL timer_irq[%0d]: got %b expected %b", i, irq, (i == 4));
      end
      if (i < 4) step();
    end
    rd(ATctrl, got);
    vectors++;
    if (got !== 32'd3) begin
      miscompares++; $display("FAIL timer_pend_set: got %h expected %h", got, 32'd3);
    end
    wr(ATctrl, 32'd3, 4'b0001);
    rd(ATctrl, got);
    vectors++;
    if (got !== 32'd1 || irq !== 1'b0) begin
      miscompares++; $display("FAIL timer_w1c: got tctrl %h irq %b expected 1 0", got, irq);
    end
    step();
    step();
    // TCNT is 3 here, so the match and the W1C land on the same edge.
    wr(ATctrl, 32'd3, 4'b0001);
    rd(ATctrl, got);
    vectors++;
    if (got !== 32'd3 || irq !== 1'b1) begin
      miscompares++; $display("FAIL timer_w1c_vs_hit: got tctrl %h irq %b expected 3 1", got, irq);
    end
    rd(ATcnt, got);
    vectors++;
    if (got !== 32'd0) begin
      miscompares++; $display("FAIL timer_wrap: got %0d expected %0d", got, 0);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] got;
    wr(32'h80, 32'hCAFE_F00D, 4'b1111);
    wr(ALed, 32'h0000_00FF, 4'b1111);
    wr(ATcnt, 32'd2, 4'b1111);
    rd(ATcnt, got);
    vectors++;
    if (got !== 32'd2 || irq !== 1'b1 || led !== 16'h00FF) begin
      miscompares++;
      $display("FAIL pre_reset_state: got tcnt %0d irq %b led %h expected 2 1 00ff", got, irq, led);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (led !== 16'h0000 || irq !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_pins: got led %h irq %b expected 0000 0", led, irq);
    end
    rd(ATcnt, got);
    vectors++;
    if (got !== 32'd0) begin
      miscompares++; $display("FAIL async_reset_tcnt: got %0d expected %0d", got, 0);
    end
    rd(32'h80, got);
    vectors++;
    if (got !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL reset_ram_kept: got %h expected %h", got, 32'hCAFE_F00D);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    step();
    rd(ATcnt, got);
    vectors++;
    if (got !== 32'd0) begin
      miscompares++; $display("FAIL post_reset_timer_off: got %0d expected %0d", got, 0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    sw       = 16'h0000;
    bus.addr = 32'h0;
    bus.wea  = 4'b0000;
    bus.din  = 32'h0;
    test_reset();
    test_ram_strobe();
    test_led();
    test_sw_sync();
    test_cycle();
    test_timer();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
